// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood mode controller.
package hood_pkg;

  typedef enum logic [2:0] {
    StOff,
    StStandby,
    StMode1,
    StMode2,
    StHurricane,
    StExitDelay
  } state_e;

  // mode_state codes seen by the downstream timing/display logic
  localparam logic [2:0] MS_STANDBY = 3'd0;
  localparam logic [2:0] MS_L1      = 3'd1;
  localparam logic [2:0] MS_L2      = 3'd2;
  localparam logic [2:0] MS_L3      = 3'd3;

  // Button indices, also the pulse priority order (lowest index wins)
  localparam int unsigned NUM_BTN   = 5;
  localparam int unsigned BTN_POWER = 0;
  localparam int unsigned BTN_MENU  = 1;
  localparam int unsigned BTN_MODE1 = 2;
  localparam int unsigned BTN_MODE2 = 3;
  localparam int unsigned BTN_MODE3 = 4;

  localparam int unsigned CD_W           = 6;
  localparam int unsigned MENU_TIMEOUT_S = 10;

  // EXIT_DELAY still runs the fan at level 2, so it reports MS_L2
  function automatic logic [2:0] mode_code(input state_e st);
    logic [2:0] code;
    code = MS_STANDBY;
    case (st)
      StMode1:     code = MS_L1;
      StMode2:     code = MS_L2;
      StHurricane: code = MS_L3;
      StExitDelay: code = MS_L2;
      default:     code = MS_STANDBY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-sample counter and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  // Synchronize the asynchronous raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level
  always_comb begin
    accept  = (sync2_q != level_q) && (cnt_q == CntLast);
    level_d = accept ? sync2_q : level_q;
    if ((sync2_q == level_q) || accept) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Debounced level and stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // High for exactly the cycle in which a rising level is accepted
  assign pulse_o = accept & sync2_q;

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood power/menu/wind-level controller with 1 Hz tick and hurricane
// countdown. Optional macro HOOD_MENU_TIMEOUT_EN: an armed standby menu
// disarms after MENU_TIMEOUT_S idle seconds.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned DEBOUNCE_CYC = 2000000,
  parameter int unsigned HURRICANE_S  = 60,
  parameter int unsigned EXIT_DELAY_S = 60
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            power_btn,
  input  logic            menu_btn,
  input  logic            mode1_btn,
  input  logic            mode2_btn,
  input  logic            mode3_btn,
  output logic            power_on,
  output logic            menu_armed,
  output logic [2:0]      mode_state,
  output logic [CD_W-1:0] countdown,
  output logic            hurricane_used,
  output logic            sec_tick
);

  if ((HURRICANE_S > 63) || (EXIT_DELAY_S > 63)) begin : g_cd_range_check
    $error("HURRICANE_S and EXIT_DELAY_S must fit in the 6-bit countdown");
  end

  localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(CLK_HZ - 1);
  localparam logic [CD_W-1:0]  HurrInit = CD_W'(HURRICANE_S);
  localparam logic [CD_W-1:0]  ExitInit = CD_W'(EXIT_DELAY_S);

  logic [NUM_BTN-1:0] raw, pulse, act;
  logic [TickW-1:0]   tick_q, tick_d;
  logic               tick_clr;
  logic               menu_timeout;
  state_e             state_q, state_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               armed_q, armed_d;
  logic               hu_q, hu_d;

  assign raw = {mode3_btn, mode2_btn, mode1_btn, menu_btn, power_btn};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (raw[i]),
      .pulse_o(pulse[i])
    );
  end

  // Keep only the highest-priority pulse of the cycle
  always_comb begin
    act = '0;
    if (pulse[BTN_POWER])      act[BTN_POWER] = 1'b1;
    else if (pulse[BTN_MENU])  act[BTN_MENU]  = 1'b1;
    else if (pulse[BTN_MODE1]) act[BTN_MODE1] = 1'b1;
    else if (pulse[BTN_MODE2]) act[BTN_MODE2] = 1'b1;
    else if (pulse[BTN_MODE3]) act[BTN_MODE3] = 1'b1;
  end

  // Free-running seconds divider, restarted on countdown entry
  always_comb begin
    sec_tick = (tick_q == TickLast);
    tick_d   = (tick_clr || sec_tick) ? '0 : tick_q + TickW'(1);
  end

`ifdef HOOD_MENU_TIMEOUT_EN
  localparam logic [3:0] ToLast = 4'(MENU_TIMEOUT_S - 1);
  logic [3:0] to_cnt_q, to_cnt_d;

  // Idle-second counter for an armed menu; any raw pulse restarts it
  always_comb begin
    to_cnt_d     = '0;
    menu_timeout = 1'b0;
    if ((state_q == StStandby) && armed_q && !(|pulse)) begin
      to_cnt_d = to_cnt_q;
      if (sec_tick) begin
        if (to_cnt_q == ToLast) begin
          menu_timeout = 1'b1;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end
    end
  end

  // Menu timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign menu_timeout = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
      cd_q    <= '0;
      armed_q <= 1'b0;
      hu_q    <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      armed_q <= armed_d;
      hu_q    <= hu_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    armed_d  = armed_q;
    hu_d     = hu_q;
    tick_clr = 1'b0;
    if ((state_q != StOff) && act[BTN_POWER]) begin
      // hurricane_used is kept until the next power-on
      state_d = StOff;
      cd_d    = '0;
      armed_d = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (act[BTN_POWER]) begin
            state_d = StStandby;
            hu_d    = 1'b0;
          end
        end
        StStandby: begin
          if (act[BTN_MENU]) begin
            armed_d = ~armed_q;
          end else if (armed_q && act[BTN_MODE1]) begin
            state_d = StMode1;
            armed_d = 1'b0;
          end else if (armed_q && act[BTN_MODE2]) begin
            state_d = StMode2;
            armed_d = 1'b0;
          end else if (armed_q && act[BTN_MODE3] && !hu_q) begin
            state_d  = StHurricane;
            armed_d  = 1'b0;
            cd_d     = HurrInit;
            hu_d     = 1'b1;
            tick_clr = 1'b1;
          end else if (menu_timeout) begin
            armed_d = 1'b0;
          end
        end
        StMode1, StMode2: begin
          if (act[BTN_MENU]) begin
            state_d = StStandby;
            armed_d = 1'b0;
          end else if (act[BTN_MODE1]) begin
            state_d = StMode1;
          end else if (act[BTN_MODE2]) begin
            state_d = StMode2;
          end else if (act[BTN_MODE3] && !hu_q) begin
            state_d  = StHurricane;
            cd_d     = HurrInit;
            hu_d     = 1'b1;
            tick_clr = 1'b1;
          end
        end
        StHurricane: begin
          if (act[BTN_MENU]) begin
            state_d  = StExitDelay;
            cd_d     = ExitInit;
            tick_clr = 1'b1;
          end else if (sec_tick) begin
            if (cd_q > CD_W'(1)) begin
              cd_d = cd_q - CD_W'(1);
            end else begin
              cd_d    = '0;
              state_d = StMode2;
            end
          end
        end
        StExitDelay: begin
          if (sec_tick) begin
            if (cd_q > CD_W'(1)) begin
              cd_d = cd_q - CD_W'(1);
            end else begin
              cd_d    = '0;
              state_d = StStandby;
            end
          end
        end
        default: begin
          state_d = StOff;
          cd_d    = '0;
          armed_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    power_on       = (state_q != StOff);
    mode_state     = mode_code(state_q);
    menu_armed     = armed_q;
    countdown      = cd_q;
    hurricane_used = hu_q;
  end

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed self-checking bench for hood_mode_ctrl (small clock/debounce values).
module tb_hood_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_btn, menu_btn, mode1_btn, mode2_btn, mode3_btn;
  logic       power_on, menu_armed, hurricane_used, sec_tick;
  logic [2:0] mode_state;
  logic [5:0] countdown;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hood_mode_ctrl #(
    .CLK_HZ      (10),
    .DEBOUNCE_CYC(4),
    .HURRICANE_S (3),
    .EXIT_DELAY_S(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .power_btn     (power_btn),
    .menu_btn      (menu_btn),
    .mode1_btn     (mode1_btn),
    .mode2_btn     (mode2_btn),
    .mode3_btn     (mode3_btn),
    .power_on      (power_on),
    .menu_armed    (menu_armed),
    .mode_state    (mode_state),
    .countdown     (countdown),
    .hurricane_used(hurricane_used),
    .sec_tick      (sec_tick)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v);
    case (idx)
      0:       power_btn = v;
      1:       menu_btn  = v;
      2:       mode1_btn = v;
      3:       mode2_btn = v;
      default: mode3_btn = v;
    endcase
  endtask

  // Raw high for 6 cycles: the FSM has reacted when this returns
  task automatic press(input int idx);
    drive(idx, 1'b1);
    step(6);
    drive(idx, 1'b0);
  endtask

  task automatic settle();
    step(8);
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1;
    step(2);
    n_cmp++;
    if ({power_on, menu_armed, hurricane_used, sec_tick} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {power_on, menu_armed, hurricane_used, sec_tick});
    end
    n_cmp++;
    if ({mode_state, countdown} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_mode_cd: got ms=%0d cd=%0d want 0/0", mode_state, countdown);
    end
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (sec_tick === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks !== 4) begin
      n_err++;
      $display("FAIL tick_rate: got %0d ticks in 40 cycles want 4", ticks);
    end
  endtask

  task automatic test_glitch();
    drive(0, 1'b1);
    step(3);
    drive(0, 1'b0);
    step(10);
    n_cmp++;
    if (power_on !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_ignored: got power_on=%b want 0", power_on);
    end
    drive(0, 1'b1);
    step(5);
    n_cmp++;
    if (power_on !== 1'b0) begin
      n_err++;
      $display("FAIL press_latency_early: got power_on=%b at 5 cycles want 0", power_on);
    end
    step(1);
    n_cmp++;
    if ((power_on !== 1'b1) || (mode_state !== 3'd0)) begin
      n_err++;
      $display("FAIL press_latency: got power_on=%b ms=%0d at 6 cycles want 1/0",
               power_on, mode_state);
    end
    step(14);
    drive(0, 1'b0);
    settle();
    n_cmp++;
    if (power_on !== 1'b1) begin
      n_err++;
      $display("FAIL hold_single_pulse: got power_on=%b want 1", power_on);
    end
  endtask

  task automatic test_menu_select();
    press(1);
    n_cmp++;
    if (menu_armed !== 1'b1) begin
      n_err++;
      $display("FAIL menu_arm: got %b want 1", menu_armed);
    end
    settle();
    press(3);
    n_cmp++;
    if ((mode_state !== 3'd2) || (menu_armed !== 1'b0)) begin
      n_err++;
      $display("FAIL sel_mode2: got ms=%0d armed=%b want 2/0", mode_state, menu_armed);
    end
    settle();
    press(2);
    n_cmp++;
    if (mode_state !== 3'd1) begin
      n_err++;
      $display("FAIL switch_mode1: got ms=%0d want 1", mode_state);
    end
    settle();
  endtask

  // Power off then on again, arm the menu and enter hurricane
  task automatic enter_hurricane_fresh();
    press(0);
    settle();
    press(0);
    settle();
    press(1);
    settle();
    press(4);
  endtask

  task automatic test_hurricane_run();
    enter_hurricane_fresh();
    n_cmp++;
    if ((mode_state !== 3'd3) || (countdown !== 6'd3) || (hurricane_used !== 1'b1)) begin
      n_err++;
      $display("FAIL hurr_entry: got ms=%0d cd=%0d hu=%b want 3/3/1",
               mode_state, countdown, hurricane_used);
    end
    step(9);
    n_cmp++;
    if (countdown !== 6'd3) begin
      n_err++;
      $display("FAIL hurr_full_second: got cd=%0d want 3", countdown);
    end
    step(1);
    n_cmp++;
    if (countdown !== 6'd2) begin
      n_err++;
      $display("FAIL hurr_cd2: got cd=%0d want 2", countdown);
    end
    step(10);
    n_cmp++;
    if (countdown !== 6'd1) begin
      n_err++;
      $display("FAIL hurr_cd1: got cd=%0d want 1", countdown);
    end
    step(9);
    n_cmp++;
    if ((countdown !== 6'd1) || (mode_state !== 3'd3)) begin
      n_err++;
      $display("FAIL hurr_before_end: got cd=%0d ms=%0d want 1/3", countdown, mode_state);
    end
    step(1);
    n_cmp++;
    if ((countdown !== 6'd0) || (mode_state !== 3'd2)) begin
      n_err++;
      $display("FAIL hurr_end: got cd=%0d ms=%0d want 0/2", countdown, mode_state);
    end
    settle();
    press(4);
    n_cmp++;
    if ((mode_state !== 3'd2) || (countdown !== 6'd0)) begin
      n_err++;
      $display("FAIL hurr_once: got ms=%0d cd=%0d want 2/0", mode_state, countdown);
    end
    settle();
  endtask

  task automatic test_hurricane_cancel();
    enter_hurricane_fresh();
    press(1);
    n_cmp++;
    if ((mode_state !== 3'd2) || (countdown !== 6'd2)) begin
      n_err++;
      $display("FAIL cancel_entry: got ms=%0d cd=%0d want 2/2", mode_state, countdown);
    end
    step(19);
    n_cmp++;
    if ((mode_state !== 3'd2) || (countdown !== 6'd1)) begin
      n_err++;
      $display("FAIL exit_mid: got ms=%0d cd=%0d want 2/1", mode_state, countdown);
    end
    step(1);
    n_cmp++;
    if ((mode_state !== 3'd0) || (countdown !== 6'd0) || (power_on !== 1'b1)) begin
      n_err++;
      $display("FAIL exit_done: got ms=%0d cd=%0d pwr=%b want 0/0/1",
               mode_state, countdown, power_on);
    end
    settle();
    press(2);
    n_cmp++;
    if ((mode_state !== 3'd0) || (menu_armed !== 1'b0)) begin
      n_err++;
      $display("FAIL unarmed_mode1: got ms=%0d armed=%b want 0/0", mode_state, menu_armed);
    end
    settle();
  endtask

  task automatic test_power_priority();
    press(0);
    n_cmp++;
    if ((power_on !== 1'b0) || (hurricane_used !== 1'b1) || (mode_state !== 3'd0)) begin
      n_err++;
      $display("FAIL power_off: got pwr=%b hu=%b ms=%0d want 0/1/0",
               power_on, hurricane_used, mode_state);
    end
    settle();
    press(0);
    n_cmp++;
    if ((power_on !== 1'b1) || (hurricane_used !== 1'b0)) begin
      n_err++;
      $display("FAIL power_on_clear_hu: got pwr=%b hu=%b want 1/0", power_on, hurricane_used);
    end
    settle();
    menu_btn  = 1'b1;
    mode3_btn = 1'b1;
    step(6);
    menu_btn  = 1'b0;
    mode3_btn = 1'b0;
    n_cmp++;
    if ((menu_armed !== 1'b1) || (mode_state !== 3'd0)) begin
      n_err++;
      $display("FAIL prio_menu_mode3: got armed=%b ms=%0d want 1/0", menu_armed, mode_state);
    end
    settle();
    menu_btn  = 1'b1;
    mode1_btn = 1'b1;
    step(6);
    menu_btn  = 1'b0;
    mode1_btn = 1'b0;
    n_cmp++;
    if ((menu_armed !== 1'b0) || (mode_state !== 3'd0)) begin
      n_err++;
      $display("FAIL prio_menu_mode1: got armed=%b ms=%0d want 0/0", menu_armed, mode_state);
    end
    settle();
  endtask

  task automatic test_async_reset();
    press(1);
    settle();
    press(4);
    step(12);
    n_cmp++;
    if ((mode_state !== 3'd3) || (countdown !== 6'd2)) begin
      n_err++;
      $display("FAIL pre_reset: got ms=%0d cd=%0d want 3/2", mode_state, countdown);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({power_on, menu_armed, hurricane_used, sec_tick, mode_state, countdown} !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset: got pwr=%b armed=%b hu=%b tick=%b ms=%0d cd=%0d want all 0",
               power_on, menu_armed, hurricane_used, sec_tick, mode_state, countdown);
    end
    step(2);
    rst = 1'b0;
    step(3);
    n_cmp++;
    if ((power_on !== 1'b0) || (mode_state !== 3'd0)) begin
      n_err++;
      $display("FAIL post_reset_off: got pwr=%b ms=%0d want 0/0", power_on, mode_state);
    end
  endtask

  task automatic test_menu_timeout();
    press(0);
    settle();
    press(1);
    step(79);
    n_cmp++;
    if (menu_armed !== 1'b1) begin
      n_err++;
      $display("FAIL menu_idle_80: got armed=%b want 1", menu_armed);
    end
    step(20);
    n_cmp++;
`ifdef HOOD_MENU_TIMEOUT_EN
    if (menu_armed !== 1'b0) begin
      n_err++;
      $display("FAIL menu_timeout: got armed=%b want 0", menu_armed);
    end
`else
    if (menu_armed !== 1'b1) begin
      n_err++;
      $display("FAIL menu_persist: got armed=%b want 1", menu_armed);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    power_btn = 1'b0;
    menu_btn  = 1'b0;
    mode1_btn = 1'b0;
    mode2_btn = 1'b0;
    mode3_btn = 1'b0;
    test_reset();
    test_glitch();
    test_menu_select();
    test_hurricane_run();
    test_hurricane_cancel();
    test_power_priority();
    test_async_reset();
    test_menu_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
Name: hood_mode_ctrl

Overview:
Upstream control stage for the range-hood fan timing block. Conditions the raw panel buttons (power, menu, 1/2/3), runs the power/menu/wind-level state machine, and generates the 1 Hz tick. Produces `mode_state[2:0]` plus the hurricane countdown consumed by the downstream timing/display logic.

Parameters:
- CLK_HZ, 100000000, input clock frequency; sets the 1 Hz tick divider.
- DEBOUNCE_CYC, 2000000, number of consecutive stable cycles needed to accept a button level.
- HURRICANE_S, 60, hurricane (level 3) run time in seconds.
- EXIT_DELAY_S, 60, forced level-2 run time in seconds after hurricane is cancelled via menu.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- power_btn  in  1  raw power button, active-high, asynchronous
- menu_btn  in  1  raw menu button
- mode1_btn  in  1  raw level-1 button
- mode2_btn  in  1  raw level-2 button
- mode3_btn  in  1  raw level-3 (hurricane) button
- power_on  out  1  high in every state except OFF
- menu_armed  out  1  standby menu is open
- mode_state  out  3  0 = standby/off, 1 = level 1, 2 = level 2, 3 = hurricane
- countdown  out  6  seconds remaining in HURRICANE or EXIT_DELAY, else 0
- hurricane_used  out  1  hurricane already consumed this power-on
- sec_tick  out  1  one-cycle pulse every CLK_HZ cycles

Behaviour:
- Reset values (async assert, sync release):
  - state = OFF; all outputs 0; tick divider 0; debounce state clear.
- Button conditioning, per button:
  - 2-FF synchronizer, then a stable counter.
  - The accepted level changes only after DEBOUNCE_CYC identical samples.
  - A one-cycle press pulse is emitted on an accepted 0->1 transition.
  - Raw edge to pulse latency = 2 + DEBOUNCE_CYC cycles.
  - Holding a button yields exactly one pulse.
- Tick generator:
  - Counts 0..CLK_HZ-1; `sec_tick` fires on the wrap cycle.
  - The divider is cleared on entry to HURRICANE or EXIT_DELAY, so the first decrement comes a full second after entry.
- Same-cycle pulse priority: power > menu > mode1 > mode2 > mode3. Only the highest-priority pulse acts; the others are dropped.
- State machine:
  - OFF:
    - power -> STANDBY.
    - `hurricane_used` is cleared on OFF->STANDBY (re-enabled once per power-on).
  - STANDBY (mode_state 0):
    - menu toggles `menu_armed`.
    - While armed: mode1 -> MODE1; mode2 -> MODE2; mode3 with !hurricane_used -> HURRICANE.
    - While armed, mode3 with hurricane_used is ignored and `menu_armed` stays 1.
    - Mode pulses while not armed are ignored.
    - Leaving STANDBY clears `menu_armed`.
  - MODE1 / MODE2:
    - mode1 / mode2 switch directly between levels.
    - mode3 with !hurricane_used -> HURRICANE; otherwise ignored.
    - menu -> STANDBY.
  - HURRICANE (mode_state 3):
    - On entry: countdown = HURRICANE_S, hurricane_used = 1.
    - On `sec_tick` with countdown > 1: decrement.
    - On `sec_tick` with countdown == 1: countdown = 0 and go to MODE2 in the same cycle.
    - menu -> EXIT_DELAY.
    - mode1 / mode2 / mode3 are ignored.
  - EXIT_DELAY (mode_state 2):
    - On entry: countdown = EXIT_DELAY_S.
    - Decrements on `sec_tick`; reaching 0 -> STANDBY.
    - All mode and menu pulses are ignored.
  - Any state except OFF: power -> OFF. countdown, menu_armed and mode_state clear next cycle; `hurricane_used` is retained until the next power-on.
- Width rules:
  - countdown is 6 bits; HURRICANE_S and EXIT_DELAY_S must be ≤ 63 (elaboration assertion).
  - Decrement never underflows.
- Reset mid-countdown returns immediately to OFF with all outputs 0.

Optional Feature:
- Macro: HOOD_MENU_TIMEOUT_EN.
- Defined: an armed menu in STANDBY auto-disarms after 10 consecutive `sec_tick`s with no accepted button pulse. Any pulse restarts the 10-second count.
- Undefined: `menu_armed` persists until menu, power, or a mode selection. The timeout counter and its logic are not generated.

Decomposition:
- Package `hood_pkg`:
  - state enum: OFF, STANDBY, MODE1, MODE2, HURRICANE, EXIT_DELAY.
  - mode_state codes: MS_STANDBY = 0, MS_L1 = 1, MS_L2 = 2, MS_L3 = 3.
  - Button index constants.
  - Menu timeout constant: 10.
- Sub-module `btn_debounce` (synchronizer, stable counter, rising-edge pulse; parameter DEBOUNCE_CYC), instantiated 5 times.

Test Plan:
Bench parameters: CLK_HZ = 10, DEBOUNCE_CYC = 4, HURRICANE_S = 3, EXIT_DELAY_S = 2.
1. Button glitch: power high for 3 cycles -> no change. Power held for 20 cycles -> power_on = 1 exactly 6 cycles after the rising edge, with a single pulse.
2. Menu select: power, menu, mode2 -> mode_state 2 and menu_armed 0. Then mode1 -> mode_state 1.
3. Hurricane run: power, menu, mode3 -> mode_state 3, countdown 3. Countdown steps 2, 1 at 10-cycle intervals. On the 3rd tick, countdown 0 and mode_state 2. A later mode3 -> no change (hurricane_used = 1).
4. Hurricane cancel: menu during HURRICANE -> mode_state 2, countdown 2. After 20 cycles, mode_state 0, state STANDBY, and mode1 without menu is ignored.
5. Power cycle and priority: power off and on -> hurricane_used 0. menu and mode3 pulses in the same cycle -> only menu acts (armed, mode_state 0).
6. Async reset: assert rst during HURRICANE with countdown 2 -> all outputs 0 in the same cycle. HOOD_MENU_TIMEOUT_EN build: an armed menu left idle for 100 cycles -> menu_armed 0.
